dm_arbiter: RTL and testbench

//   Two-port arbiter/sequencer for the single-port data memory (DM). Shares DM between

---
 rtl/dm_arbiter.sv | 152 +++++++++++++++
 tb/tb_dm_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin sequencer sharing the single-port data memory between two requesters.
// One transaction in flight: IDLE -> ACCESS (DM strobe) -> RESP (ack + read data).
module dm_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              DM_enable,
  output logic              DM_write,
  output logic [ADDR_W-1:0] DM_address,
  output logic [DATA_W-1:0] DM_in,
  input  logic [DATA_W-1:0] DM_out
);

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic              oor_q, oor_d;
  logic              dm_en_q, dm_en_d;
  logic              dm_wr_q, dm_wr_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_in_q, dm_in_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              err0_q, err0_d;
  logic              err1_q, err1_d;

  logic              elig0, elig1, gnt_w;
  logic              sel_we, sel_oor;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // The requester just acked in RESP is masked so the other side gets the next slot.
  assign elig0     = req0 && !((state_q == S_RESP) && !win_q);
  assign elig1     = req1 && !((state_q == S_RESP) && win_q);
  assign gnt_w     = (elig0 && elig1) ? rr_q : elig1;
  assign sel_we    = gnt_w ? we1 : we0;
  assign sel_addr  = gnt_w ? addr1 : addr0;
  assign sel_wdata = gnt_w ? wdata1 : wdata0;
  assign sel_oor   = {1'b0, sel_addr} >= DEPTH_EXT;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    win_d     = win_q;
    we_d      = we_q;
    oor_d     = oor_q;
    dm_en_d   = 1'b0;
    dm_wr_d   = 1'b0;
    dm_addr_d = '0;
    dm_in_d   = '0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (elig0 || elig1) begin
          state_d   = S_ACCESS;
          win_d     = gnt_w;
          rr_d      = ~gnt_w;
          we_d      = sel_we;
          oor_d     = sel_oor;
          dm_en_d   = ~sel_oor;
          dm_wr_d   = sel_we;
          dm_addr_d = sel_addr;
          dm_in_d   = sel_wdata;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        ack0_d  = ~win_q;
        ack1_d  = win_q;
        err0_d  = ~win_q & oor_q;
        err1_d  = win_q & oor_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rr_q      <= 1'b0;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      oor_q     <= 1'b0;
      dm_en_q   <= 1'b0;
      dm_wr_q   <= 1'b0;
      dm_addr_q <= '0;
      dm_in_q   <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      win_q     <= win_d;
      we_q      <= we_d;
      oor_q     <= oor_d;
      dm_en_q   <= dm_en_d;
      dm_wr_q   <= dm_wr_d;
      dm_addr_q <= dm_addr_d;
      dm_in_q   <= dm_in_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
    end
  end

  // DM_out is only valid during RESP, so read data is gated from it by the registered ack.
  assign rdata0     = (ack0_q && !we_q && !err0_q) ? DM_out : '0;
  assign rdata1     = (ack1_q && !we_q && !err1_q) ? DM_out : '0;
  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign err0       = err0_q;
  assign err1       = err1_q;
  assign DM_enable  = dm_en_q;
  assign DM_write   = dm_wr_q;
  assign DM_address = dm_addr_q;
  assign DM_in      = dm_in_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed scenarios plus random two-requester traffic, checked every cycle
// against a transaction-level model of grants, latencies and memory contents.
module tb_dm_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err0, err1, DM_enable, DM_write;
  logic [DW-1:0] rdata0, rdata1, DM_in;
  logic [DW-1:0] DM_out = '0;
  logic [AW-1:0] DM_address;

  dm_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .DM_enable(DM_enable), .DM_write(DM_write), .DM_address(DM_address),
    .DM_in(DM_in), .DM_out(DM_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory device: registered read data, one cycle after the read strobe.
  logic [DW-1:0] dm_mem  [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  initial begin
    forever begin
      @(posedge clk);
      if (DM_enable && (DM_address < AW'(DEPTH))) begin
        if (DM_write) dm_mem[DM_address] = DM_in;
        else DM_out = dm_mem[DM_address];
      end
    end
  end

  // Reference model: a grant may happen 2+ cycles after the previous one; exactly 2 cycles
  // later the previous winner is excluded. Ack lands one cycle after the access cycle.
  int            cyc = 0;
  int            last_g = -100;
  bit            last_w = 1'b0;
  bit            rr = 1'b0;
  bit            pend_v = 1'b0, pend_who = 1'b0, pend_we = 1'b0, pend_err = 1'b0;
  int            pend_g = 0;
  logic [AW-1:0] pend_addr = '0;
  logic [DW-1:0] pend_wdata = '0, pend_rd = '0;
  int            en_count = 0;

  initial begin
    bit e0, e1, w;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        pend_v = 1'b0;
        last_g = -100;
        rr     = 1'b0;
      end else if (clk) begin
        cyc++;
        if (cyc >= last_g + 2) begin
          e0 = req0 && !(cyc == last_g + 2 && last_w == 1'b0);
          e1 = req1 && !(cyc == last_g + 2 && last_w == 1'b1);
          if (e0 || e1) begin
            w          = (e0 && e1) ? rr : e1;
            rr         = !w;
            last_g     = cyc;
            last_w     = w;
            pend_v     = 1'b1;
            pend_g     = cyc;
            pend_who   = w;
            pend_we    = w ? we1 : we0;
            pend_addr  = w ? addr1 : addr0;
            pend_wdata = w ? wdata1 : wdata0;
            pend_err   = pend_addr >= AW'(DEPTH);
            pend_rd    = '0;
            if (!pend_err) begin
              if (pend_we) ref_mem[pend_addr] = pend_wdata;
              else pend_rd = ref_mem[pend_addr];
            end
          end
        end
      end
    end
  end

  // Per-cycle monitor on the falling edge.
  always @(negedge clk) begin
    bit in_acc, ea0, ea1;
    if (DM_enable) en_count++;
    if (!rst) begin
      check("rst_ctl", 64'({ack0, ack1, err0, err1, DM_enable, DM_write}), 64'd0);
      check("rst_data", 64'(DM_address | DM_in | rdata0 | rdata1), 64'd0);
    end else begin
      in_acc = pend_v && (cyc == pend_g);
      ea0    = pend_v && (cyc == pend_g + 1) && !pend_who;
      ea1    = pend_v && (cyc == pend_g + 1) && pend_who;
      check("ack", 64'({ack1, ack0}), 64'({ea1, ea0}));
      check("err", 64'({err1, err0}), 64'({ea1 && pend_err, ea0 && pend_err}));
      check("rdata0", 64'(rdata0), ea0 ? 64'(pend_rd) : 64'd0);
      check("rdata1", 64'(rdata1), ea1 ? 64'(pend_rd) : 64'd0);
      check("dm_en", 64'(DM_enable), 64'(in_acc && !pend_err));
      if (in_acc) begin
        check("dm_ctl", 64'({DM_write, DM_address}), 64'({pend_we, pend_addr}));
        if (pend_we) check("dm_in", 64'(DM_in), 64'(pend_wdata));
      end else begin
        check("dm_idle", 64'({DM_write, DM_address | DM_in}), 64'd0);
      end
    end
  end

  task automatic set_req(input bit who, input bit r, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    if (who) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  task automatic do_req(input bit who, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output logic [DW-1:0] rd, output logic er,
                        output int lat);
    @(negedge clk);
    set_req(who, 1'b1, w, a, d);
    lat = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (who ? ack1 : ack0) begin
        lat = i;
        rd  = who ? rdata1 : rdata0;
        er  = who ? err1 : err0;
      end
    end
    if (who) req1 = 1'b0; else req0 = 1'b0;
    if (lat == 0) check("ack_timeout", 64'd1, 64'd0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 15);
    if (r == 0) return AW'(DEPTH + $urandom_range(0, 3));
    if (r == 1) return AW'($urandom);
    if (r == 2) return AW'(DEPTH - 1);
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic rand_drive(input bit who, input int ncyc);
    bit busy;
    busy = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (busy && (who ? ack1 : ack0)) busy = 1'b0;
      else if (busy && $urandom_range(0, 31) == 0) busy = 1'b0;
      if (!busy && $urandom_range(0, 2) == 0) begin
        busy = 1'b1;
        set_req(who, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
      end else if (!busy) begin
        if (who) req1 = 1'b0; else req0 = 1'b0;
      end
    end
    if (who) req1 = 1'b0; else req0 = 1'b0;
  endtask

  logic [DW-1:0] rd_a, rd_b;
  logic          er_a, er_b;
  int            lat_a, lat_b, n_ack, last_ack, en_before, late_acks;

  initial begin
    rst = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      dm_mem[i]  = DW'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
      ref_mem[i] = DW'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;

    // Contention straight out of reset: requester 0 first, requester 1 two cycles later.
    fork
      do_req(1'b0, 1'b0, AW'(10), '0, rd_a, er_a, lat_a);
      do_req(1'b1, 1'b0, AW'(11), '0, rd_b, er_b, lat_b);
    join
    check("t2_lat0", 64'(lat_a), 64'd2);
    check("t2_lat1", 64'(lat_b), 64'd4);
    check("t2_rd1", 64'(rd_b), 64'(32'h5A5A_0000 ^ (32'd11 * 32'h0101_0101)));

    // Both held continuously: acks alternate every 2 cycles starting with requester 0.
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, AW'(1), '0);
    set_req(1'b1, 1'b1, 1'b0, AW'(2), '0);
    n_ack = 0; last_ack = 0;
    for (int i = 0; i < 20 && n_ack < 4; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        check("t2_alt_who", 64'(ack1), 64'(n_ack % 2));
        if (n_ack > 0) check("t2_alt_gap", 64'(i - last_ack), 64'd2);
        last_ack = i;
        n_ack++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("t2_alt_count", 64'(n_ack), 64'd4);
    repeat (2) @(negedge clk);

    // Write then read back on requester 0.
    do_req(1'b0, 1'b1, AW'(5), 32'hDEAD_BEEF, rd_a, er_a, lat_a);
    check("t1_wr_lat", 64'(lat_a), 64'd2);
    check("t1_wr_rd", 64'(rd_a), 64'd0);
    do_req(1'b0, 1'b0, AW'(5), '0, rd_a, er_a, lat_a);
    check("t1_rd", 64'(rd_a), 64'(32'hDEAD_BEEF));
    check("t1_err", 64'(er_a), 64'd0);

    // Cycle timing of a read of a preloaded word.
    dm_mem[7] = 32'h1234; ref_mem[7] = 32'h1234;
    do_req(1'b0, 1'b0, AW'(7), '0, rd_a, er_a, lat_a);
    check("t4_lat", 64'(lat_a), 64'd2);
    check("t4_rd", 64'(rd_a), 64'h1234);

    // Out of range: no DM strobe, err with zero data on the normal schedule.
    en_before = en_count;
    do_req(1'b1, 1'b0, AW'(DEPTH), '0, rd_b, er_b, lat_b);
    check("t3_lat", 64'(lat_b), 64'd2);
    check("t3_err", 64'(er_b), 64'd1);
    check("t3_rd", 64'(rd_b), 64'd0);
    check("t3_no_en", 64'(en_count - en_before), 64'd0);

    // Write isolation between requesters.
    do_req(1'b1, 1'b1, AW'(3), 32'hA5A5_A5A5, rd_b, er_b, lat_b);
    check("t6_wr_rd", 64'(rd_b), 64'd0);
    check("t6_wr_err", 64'(er_b), 64'd0);
    do_req(1'b0, 1'b0, AW'(3), '0, rd_a, er_a, lat_a);
    check("t6_rd", 64'(rd_a), 64'(32'hA5A5_A5A5));

    // Reset during ACCESS: outputs clear at once and the abandoned request never acks.
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, AW'(9), '0);
    @(negedge clk);
    check("t5_access", 64'(DM_enable), 64'd1);
    #2 rst = 1'b0;
    #1 check("t5_rst_now", 64'({ack0, ack1, DM_enable, DM_write}), 64'd0);
    req0 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    late_acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack0 || ack1) late_acks++;
    end
    check("t5_no_ack", 64'(late_acks), 64'd0);
    fork
      do_req(1'b0, 1'b0, AW'(12), '0, rd_a, er_a, lat_a);
      do_req(1'b1, 1'b0, AW'(13), '0, rd_b, er_b, lat_b);
    join
    check("t5_lat0", 64'(lat_a), 64'd2);
    check("t5_lat1", 64'(lat_b), 64'd4);

    // Random traffic from both requesters.
    fork
      rand_drive(1'b0, 1500);
      rand_drive(1'b1, 1500);
    join
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
